// File: rtl/fixed_point_seq_unit_pkg.sv
// Shared definitions for the sequential fixed-point arithmetic unit:
// operation codes, FSM state encoding, default geometry and the helpers
// that derive the slice count and square-root iteration count from it.
package fixed_point_seq_unit_pkg;

  typedef enum logic [1:0] {
    FPU_ADD  = 2'b00,
    FPU_SUB  = 2'b01,
    FPU_MUL  = 2'b10,
    FPU_SQRT = 2'b11
  } fpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_SQRT   = 3'd3,
    ST_FIN    = 3'd4
  } fpu_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 10;
  localparam int DEF_CHUNK = 16;

  // Slices per operand.
  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Root iterations: two radicand bits retire per step.
  function automatic int calc_iter(input int width, input int fbits);
    return (width + fbits) / 2;
  endfunction

  localparam int N_DEF    = calc_n(DEF_WIDTH, DEF_CHUNK);
  localparam int ITER_DEF = calc_iter(DEF_WIDTH, DEF_FBITS);

endpackage

// File: rtl/fixed_point_seq_unit_slice_multiplier.sv
// Combinational unsigned CHUNK x CHUNK multiplier. The sequential unit
// owns a single instance and steps it across all slice pairs.
//   a, b    : unsigned CHUNK-bit slices
//   product : full 2*CHUNK-bit unsigned product
module slice_multiplier #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]   a,
  input  logic [CHUNK-1:0]   b,
  output logic [2*CHUNK-1:0] product
);

  localparam int PW = 2 * CHUNK;

  assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/fixed_point_seq_unit.sv
// Sequential signed Q(WIDTH-FBITS).FBITS arithmetic unit: ADD, SUB, MUL
// (one slice product per cycle) and SQRT (non-restoring, two radicand bits
// per cycle), with saturating or wrapping results.
//   clk, reset          : clock, asynchronous active-high reset
//   start, operation    : request and op code, taken when busy is low
//   operand_1/operand_2 : signed operands (operand_1 is the SQRT radicand)
//   result              : held from done until the next completion
//   busy                : from the cycle after acceptance through done
//   done                : one-cycle completion pulse
//   overflow, invalid   : range overflow / negative SQRT radicand
module fixed_point_seq_unit
  import fixed_point_seq_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 10,
  parameter int CHUNK    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             invalid
);

  localparam int N     = calc_n(WIDTH, CHUNK);
  localparam int NN    = N * N;
  localparam int ITER  = calc_iter(WIDTH, FBITS);
  localparam int AW    = 2 * WIDTH;
  localparam int RW    = WIDTH + FBITS;
  localparam int IDX_W = $clog2(NN + 1);
  localparam int IT_W  = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] clamp(input logic neg);
    return neg ? MIN_NEG : MAX_POS;
  endfunction

  // Round the magnitude half-up, extract the integer window, check range,
  // re-apply the sign and clamp if enabled. Returns {overflow, result}.
  function automatic logic [WIDTH:0] mul_finish(input logic [AW-1:0] prod,
                                                input logic          neg);
    logic [AW-1:0]    rnd;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] res;
    logic             ovf;
    rnd = prod + (AW'(1) << (FBITS - 1));
    mag = WIDTH'(rnd >> FBITS);
    ovf = ((rnd >> (WIDTH + FBITS)) != '0) ||
          (neg ? (mag > MIN_NEG) : mag[WIDTH-1]);
    res = neg ? (~mag + WIDTH'(1)) : mag;
    if (ovf && SATURATE) res = clamp(neg);
    return {ovf, res};
  endfunction

  fpu_state_e state, state_next;
  logic [IDX_W-1:0] idx;
  logic [IT_W-1:0]  iter;
  logic             accept;

  // Operands captured at acceptance
  fpu_op_e                 op_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0]        a_mag_p0;
  logic [WIDTH-1:0]        b_mag_p0;
  logic                    sign_p0;
  logic                    neg_p0;

  // Iterative working state
  logic [AW-1:0]           acc_p1;
  logic [RW-1:0]           rad_p1;
  logic signed [WIDTH+1:0] rem_p1;
  logic [WIDTH-1:0]        root_p1;

  logic signed [WIDTH:0]   sum;
  logic                    add_ovf;
  logic [WIDTH-1:0]        add_res;
  logic [WIDTH:0]          mul_out;

  int                      si;
  int                      sj;
  logic [CHUNK-1:0]        slice_a;
  logic [CHUNK-1:0]        slice_b;
  logic [2*CHUNK-1:0]      slice_prod;
  logic [AW-1:0]           partial;

  logic [1:0]              pair;
  logic signed [WIDTH+1:0] rem_sh;
  logic signed [WIDTH+1:0] rem_nx;

  assign accept = start && !busy;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (operation)
            FPU_ADD, FPU_SUB: state_next = ST_ADDSUB;
            FPU_MUL:          state_next = ST_MUL;
            FPU_SQRT:         state_next = operand_1[WIDTH-1] ? ST_FIN : ST_SQRT;
            default:          state_next = ST_IDLE;
          endcase
        end
      end
      ST_ADDSUB: state_next = ST_IDLE;
      ST_MUL:    if (idx == IDX_W'(NN - 1)) state_next = ST_FIN;
      ST_SQRT:   if (iter == IT_W'(ITER - 1)) state_next = ST_FIN;
      ST_FIN:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Add/subtract with one guard bit
  always_comb begin
    if (op_p0 == FPU_SUB) sum = {a_p0[WIDTH-1], a_p0} - {b_p0[WIDTH-1], b_p0};
    else                  sum = {a_p0[WIDTH-1], a_p0} + {b_p0[WIDTH-1], b_p0};
    add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    add_res = (add_ovf && SATURATE) ? clamp(sum[WIDTH]) : sum[WIDTH-1:0];
  end

  // Slice pair selection: idx walks A slices fastest, then B slices
  always_comb begin
    si      = int'(idx) % N;
    sj      = int'(idx) / N;
    slice_a = CHUNK'(a_mag_p0 >> (CHUNK * si));
    slice_b = CHUNK'(b_mag_p0 >> (CHUNK * sj));
  end

  slice_multiplier #(.CHUNK(CHUNK)) u_slice_mul (
    .a       (slice_a),
    .b       (slice_b),
    .product (slice_prod)
  );

  assign partial = AW'(slice_prod) << (CHUNK * (si + sj));
  assign mul_out = mul_finish(acc_p1, sign_p0);

  // Non-restoring root step: subtract 4q+1 while the remainder is
  // non-negative, otherwise add 4q+3; the new root bit is the result sign.
  assign pair = rad_p1[RW-1 -: 2];
  always_comb begin
    rem_sh = (rem_p1 <<< 2) | $signed({{WIDTH{1'b0}}, pair});
    if (rem_p1[WIDTH+1]) rem_nx = rem_sh + $signed({root_p1, 2'b11});
    else                 rem_nx = rem_sh - $signed({root_p1, 2'b01});
  end

  // Control and architecturally visible outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      idx      <= '0;
      iter     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy still high here only during the done cycle
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            idx      <= '0;
            iter     <= '0;
          end
        end
        ST_ADDSUB: begin
          result   <= add_res;
          overflow <= add_ovf;
          done     <= 1'b1;
        end
        ST_MUL:  idx  <= idx + IDX_W'(1);
        ST_SQRT: iter <= iter + IT_W'(1);
        ST_FIN: begin
          done <= 1'b1;
          if (op_p0 == FPU_MUL) begin
            result   <= mul_out[WIDTH-1:0];
            overflow <= mul_out[WIDTH];
          end else if (neg_p0) begin
            result  <= '0;
            invalid <= 1'b1;
          end else begin
            result <= root_p1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      op_p0    <= fpu_op_e'(operation);
      a_p0     <= operand_1;
      b_p0     <= operand_2;
      a_mag_p0 <= operand_1[WIDTH-1] ? (~operand_1 + WIDTH'(1)) : operand_1;
      b_mag_p0 <= operand_2[WIDTH-1] ? (~operand_2 + WIDTH'(1)) : operand_2;
      sign_p0  <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
      neg_p0   <= operand_1[WIDTH-1];
      acc_p1   <= '0;
      rad_p1   <= RW'(operand_1) << FBITS;
      rem_p1   <= '0;
      root_p1  <= '0;
    end else if (state == ST_MUL) begin
      acc_p1 <= acc_p1 + partial;
    end else if (state == ST_SQRT) begin
      rem_p1  <= rem_nx;
      root_p1 <= {root_p1[WIDTH-2:0], ~rem_nx[WIDTH+1]};
      rad_p1  <= rad_p1 << 2;
    end
  end

endmodule

// File: tb/tb_fixed_point_seq_unit.sv
// Bench for fixed_point_seq_unit: directed and random operations checked by
// a queue scoreboard against an arithmetic reference model. A second
// instance built with SATURATE=0 runs in lockstep for wrap-mode results.
module tb_fixed_point_seq_unit;
  import fixed_point_seq_unit_pkg::*;

  localparam int W  = 32;
  localparam int F  = 10;
  localparam int C  = 16;
  localparam int NN = (W / C) * (W / C);
  localparam int IT = (W + F) / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   operation = 2'b00;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic [W-1:0] result, result_w;
  logic         busy, done, overflow, invalid;
  logic         busy_w, done_w, overflow_w, invalid_w;

  fixed_point_seq_unit #(.WIDTH(W), .FBITS(F), .CHUNK(C), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_1(operand_1), .operand_2(operand_2), .result(result),
    .busy(busy), .done(done), .overflow(overflow), .invalid(invalid));

  fixed_point_seq_unit #(.WIDTH(W), .FBITS(F), .CHUNK(C), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_1(operand_1), .operand_2(operand_2), .result(result_w),
    .busy(busy_w), .done(done_w), .overflow(overflow_w), .invalid(invalid_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         inv;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t         q[$];
  exp_t         qw[$];
  exp_t         me;
  exp_t         mw;
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  // Reference model: plain integer arithmetic on the represented values.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit sat,
                                output logic [W-1:0] res, output logic ovf,
                                output logic inv);
    longint sa, sb, s, ma, mb, p, qm, v, x, lo, hi, mid, lim;
    longint maxv, minv;
    bit     neg;
    maxv = 64'sd2147483647;
    minv = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; ovf = 1'b0; inv = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b01) ? sa - sb : sa + sb;
        if (s > maxv || s < minv) begin
          ovf = 1'b1;
          res = sat ? ((s > 0) ? W'(maxv) : W'(minv)) : W'(s);
        end else begin
          res = W'(s);
        end
      end
      2'b10: begin
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        p   = ma * mb;
        qm  = (p + (64'sd1 <<< (F - 1))) >>> F;
        neg = (sa < 0) != (sb < 0);
        lim = neg ? 64'sd2147483648 : maxv;
        ovf = qm > lim;
        v   = neg ? -qm : qm;
        res = (ovf && sat) ? (neg ? W'(minv) : W'(maxv)) : W'(v);
      end
      default: begin
        if (sa < 0) begin
          inv = 1'b1;
        end else begin
          x  = sa <<< F;
          lo = 0;
          hi = 64'sd1 <<< IT;
          while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid - 1;
          end
          res = W'(lo);
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit directed,
                       input logic [W-1:0] dres, input logic dovf,
                       input logic dinv, input bit hold);
    exp_t e, ew;
    int   waited;
    bit   ok;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
      else       waited++;
    end
    if (!ok) begin
      fail_now("issue_wait");
      return;
    end
    operation = op;
    operand_1 = a;
    operand_2 = b;
    start     = 1'b1;
    model(op, a, b, 1'b1, e.res, e.ovf, e.inv);
    if (directed) begin
      e.res = dres;
      e.ovf = dovf;
      e.inv = dinv;
    end
    e.acc_cyc = cyc + 1;
    if (op == 2'b10)                 e.lat = NN + 1;
    else if (op == 2'b11 && !a[W-1]) e.lat = IT + 1;
    else                             e.lat = 1;
    model(op, a, b, 1'b0, ew.res, ew.ovf, ew.inv);
    ew.acc_cyc = e.acc_cyc;
    ew.lat     = e.lat;
    q.push_back(e);
    qw.push_back(ew);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain");
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = W'($urandom());
      1: v = W'($urandom_range(0, 32'h3FFFF));
      2: v = -W'($urandom_range(0, 32'h3FFFF));
      default: begin
        case ($urandom_range(0, 4))
          0:       v = 32'h7FFFFFFF;
          1:       v = 32'h80000000;
          2:       v = 32'h00000000;
          3:       v = 32'h00000400;
          default: v = 32'hFFFFFFFF;
        endcase
      end
    endcase
    return v;
  endfunction

  // Monitor: pops one expectation per done, checks hold between dones.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_res = '0;
      end else begin
        if (done) begin
          if (q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            me = q.pop_front();
            check("result", result, me.res);
            check("overflow", overflow, me.ovf);
            check("invalid", invalid, me.inv);
            check("latency", cyc - me.acc_cyc, me.lat);
            check("busy_in_done", busy, 1);
          end
          last_res = result;
        end else begin
          check("result_hold", result, last_res);
        end
        if (done_w) begin
          if (qw.size() == 0) begin
            fail_now("unexpected_done_wrap");
          end else begin
            mw = qw.pop_front();
            check("wrap_result", result_w, mw.res);
            check("wrap_overflow", overflow_w, mw.ovf);
            check("wrap_invalid", invalid_w, mw.inv);
            check("wrap_latency", cyc - mw.acc_cyc, mw.lat);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [1:0] alt [4];
    alt[0] = FPU_ADD; alt[1] = FPU_MUL; alt[2] = FPU_SUB; alt[3] = FPU_SQRT;

    repeat (3) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overflow", overflow, 0);
    check("reset_invalid", invalid, 0);
    reset = 1'b0;

    // Directed vectors
    issue(FPU_ADD,  32'h00000400, 32'h00000600, 1, 32'h00000A00, 0, 0, 0);
    issue(FPU_ADD,  32'h7FFFFFFF, 32'h00000400, 1, 32'h7FFFFFFF, 1, 0, 0);
    issue(FPU_SUB,  32'h80000000, 32'h00000400, 1, 32'h80000000, 1, 0, 0);
    issue(FPU_MUL,  32'h00000600, 32'h00000800, 1, 32'h00000C00, 0, 0, 0);
    issue(FPU_MUL,  32'hFFFFFA00, 32'h00000800, 1, 32'hFFFFF400, 0, 0, 0);
    issue(FPU_MUL,  32'h40000000, 32'h40000000, 1, 32'h7FFFFFFF, 1, 0, 0);
    issue(FPU_MUL,  32'h80000000, 32'h00000400, 1, 32'h80000000, 0, 0, 0);
    issue(FPU_MUL,  32'h80000000, 32'h80000000, 1, 32'h7FFFFFFF, 1, 0, 0);
    issue(FPU_MUL,  32'h00000001, 32'h00000200, 1, 32'h00000001, 0, 0, 0);
    issue(FPU_MUL,  32'hFFFFFFFF, 32'h00000200, 1, 32'hFFFFFFFF, 0, 0, 0);
    issue(FPU_SQRT, 32'h00001000, 32'h0,        1, 32'h00000800, 0, 0, 0);
    issue(FPU_SQRT, 32'h00000800, 32'h0,        1, 32'h000005A8, 0, 0, 0);
    issue(FPU_SQRT, 32'hFFFFFC00, 32'h0,        1, 32'h00000000, 0, 1, 0);
    issue(FPU_SQRT, 32'h00000000, 32'h0,        1, 32'h00000000, 0, 0, 0);
    issue(FPU_SQRT, 32'h7FFFFFFF, 32'h0,        0, '0, 0, 0, 0);
    drain();

    // start held high across alternating operations
    for (int i = 0; i < 8; i++)
      issue(alt[i % 4], rnd_operand(), rnd_operand(), 0, '0, 0, 0, 1);
    start = 1'b0;
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, rnd_operand(), rnd_operand(), 0, '0, 0, 0, bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    drain();

    // Reset in the middle of a square root
    issue(FPU_ADD, 32'h00000400, 32'h00000600, 1, 32'h00000A00, 0, 0, 0);
    issue(FPU_SQRT, 32'h00100000, 32'h0, 0, '0, 0, 0, 0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_result", result, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_overflow", overflow, 0);
    check("async_reset_invalid", invalid, 0);
    check("async_reset_result_wrap", result_w, 0);
    q.delete();
    qw.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    issue(FPU_ADD, 32'h00000400, 32'h00000600, 1, 32'h00000A00, 0, 0, 0);
    drain();
    repeat (30) @(negedge clk);

    check("queue_empty", q.size(), 0);
    check("queue_empty_wrap", qw.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
